// File: rtl/tx_gearbox_sequencer.sv
// Gearbox sequencer for a 64b/66b-style TX path: brings the encoder up after a hold-off,
// then cycles the gearbox sequence, pause, half-word select and MAC ready; all outputs registered.
module tx_gearbox_sequencer #(
  parameter int SEQ_MAX    = 32,
  parameter int INIT_HOLD  = 4,
  parameter int READY_LEAD = 1
) (
  input  logic       i_txc,
  input  logic       i_reset,
  input  logic       i_init_done,
  input  logic       i_force_resync,
  input  logic       i_mac_valid,
  output logic [5:0] o_gearbox_seq,
  output logic       o_tx_pause,
  output logic       o_frame_word,
  output logic       o_tx_ready,
  output logic       o_enc_init_done,
  output logic       o_seq_err
);

  localparam int SW = (SEQ_MAX < 2) ? 1 : $clog2(SEQ_MAX + 1);
  localparam logic [SW-1:0] SEQ_LAST  = SW'(SEQ_MAX);
  localparam logic [SW-1:0] SEQ_PRE   = SW'(SEQ_MAX - 1);
  localparam logic [7:0]    HOLD_LAST = 8'(INIT_HOLD - 1);

  typedef enum logic [1:0] {WAIT_INIT, HOLD, RUN} state_t;

  state_t        state_q, state_d;
  logic [7:0]    hold_q, hold_d;
  logic [SW-1:0] seq_q, seq_d;
  logic          pause_q, pause_d;
  logic          fw_q, fw_d;
  logic          rdy_q, rdy_d;
  logic          enc_q, enc_d;
  logic          err_q, err_d;
  logic          run_d;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    seq_d   = '0;
    case (state_q)
      WAIT_INIT: begin
        if (i_init_done) begin
          state_d = HOLD;
          hold_d  = '0;
        end
      end
      HOLD: begin
        if (!i_init_done) begin
          state_d = WAIT_INIT;
          hold_d  = '0;
        end else if (hold_q == HOLD_LAST) begin
          state_d = RUN;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      RUN: begin
        // Resync wins over both the natural wrap and a pause that was about to start.
        if (!i_init_done) begin
          state_d = WAIT_INIT;
        end else if (i_force_resync || (seq_q == SEQ_LAST)) begin
          seq_d = '0;
        end else begin
          seq_d = seq_q + SW'(1);
        end
      end
      default: state_d = WAIT_INIT;
    endcase

    run_d   = (state_d == RUN);
    pause_d = run_d && (seq_d == SEQ_LAST);
    fw_d    = 1'b0;
    if (run_d) begin
      fw_d = pause_d ? fw_q : seq_d[0];
    end
    // With a one-cycle lead, ready drops one cycle ahead of the pause it protects.
    if (READY_LEAD == 0) begin
      rdy_d = run_d && !pause_d;
    end else begin
      rdy_d = run_d && (seq_d != SEQ_PRE);
    end
    enc_d = run_d;
    err_d = err_q | ((state_q == RUN) && i_mac_valid && !rdy_q);
  end

  always_ff @(posedge i_txc) begin
    if (i_reset) begin
      state_q <= WAIT_INIT;
      hold_q  <= '0;
      seq_q   <= '0;
      pause_q <= 1'b0;
      fw_q    <= 1'b0;
      rdy_q   <= 1'b0;
      enc_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      seq_q   <= seq_d;
      pause_q <= pause_d;
      fw_q    <= fw_d;
      rdy_q   <= rdy_d;
      enc_q   <= enc_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    o_gearbox_seq           = '0;
    o_gearbox_seq[SW-1:0]   = seq_q;
  end

  assign o_tx_pause      = pause_q;
  assign o_frame_word    = fw_q;
  assign o_tx_ready      = rdy_q;
  assign o_enc_init_done = enc_q;
  assign o_seq_err       = err_q;

endmodule

// File: tb/tb_tx_gearbox_sequencer.sv
// Bench for tx_gearbox_sequencer: default instance plus a READY_LEAD=0 instance on shared inputs,
// checked against a position-in-period reference model.
module tb_tx_gearbox_sequencer;

  localparam int SEQ_MAX   = 32;
  localparam int INIT_HOLD = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic init = 1'b0;
  logic resync = 1'b0;
  logic mac = 1'b0;

  logic [5:0] seq1, seq0;
  logic pause1, fw1, rdy1, enc1, err1;
  logic pause0, fw0, rdy0, enc0, err0;

  tx_gearbox_sequencer dut (
    .i_txc(clk), .i_reset(rst), .i_init_done(init), .i_force_resync(resync), .i_mac_valid(mac),
    .o_gearbox_seq(seq1), .o_tx_pause(pause1), .o_frame_word(fw1), .o_tx_ready(rdy1),
    .o_enc_init_done(enc1), .o_seq_err(err1)
  );

  tx_gearbox_sequencer #(.READY_LEAD(0)) dut0 (
    .i_txc(clk), .i_reset(rst), .i_init_done(init), .i_force_resync(resync), .i_mac_valid(mac),
    .o_gearbox_seq(seq0), .o_tx_pause(pause0), .o_frame_word(fw0), .o_tx_ready(rdy0),
    .o_enc_init_done(enc0), .o_seq_err(err0)
  );

  always #5 clk = ~clk;

  wire [10:0] act1 = {seq1, pause1, fw1, rdy1, enc1, err1};
  wire [10:0] act0 = {seq0, pause0, fw0, rdy0, enc0, err0};

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: mode 0 = waiting, 1 = holding, 2 = running; m_pos counts cycles since run start or resync.
  int m_mode = 0;
  int m_hold = 0;
  int m_pos = 0;
  bit m_err1 = 0, m_err0 = 0;
  int e_seq = 0;
  bit e_pause = 0, e_fw = 0, e_rdy1 = 0, e_rdy0 = 0, e_enc = 0;

  function automatic logic [10:0] exp_vec(input bit lead);
    return {6'(e_seq), e_pause, e_fw, lead ? e_rdy1 : e_rdy0, e_enc, lead ? m_err1 : m_err0};
  endfunction

  task automatic tick();
    int s;
    bit run;
    @(posedge clk);
    if (rst) begin
      m_mode = 0; m_hold = 0; m_pos = 0; m_err1 = 0; m_err0 = 0;
    end else begin
      if (m_mode == 2 && mac && !e_rdy1) m_err1 = 1;
      if (m_mode == 2 && mac && !e_rdy0) m_err0 = 1;
      case (m_mode)
        0: if (init) begin m_mode = 1; m_hold = 0; end
        1: if (!init) m_mode = 0;
           else begin
             m_hold++;
             if (m_hold == INIT_HOLD) begin m_mode = 2; m_pos = 0; end
           end
        default: if (!init) m_mode = 0;
                 else if (resync) m_pos = 0;
                 else m_pos++;
      endcase
    end
    run = (m_mode == 2);
    s = m_pos % (SEQ_MAX + 1);
    e_enc   = run;
    e_seq   = run ? s : 0;
    e_pause = run && (s == SEQ_MAX);
    e_fw    = run && ((s == SEQ_MAX) ? ((SEQ_MAX - 1) % 2 == 1) : (s % 2 == 1));
    e_rdy1  = run && (s != SEQ_MAX - 1);
    e_rdy0  = run && (s != SEQ_MAX);
    #1;
  endtask

  task automatic run_until(input int target, input string tag);
    int k = 0;
    while (int'(seq1) != target && k < 200) begin
      tick();
      k++;
    end
    n_cmp++;
    if (int'(seq1) != target) begin
      n_fail++;
      $display("FAIL %s timeout: seq=%0d wanted %0d", tag, seq1, target);
    end
  endtask

  task automatic test_reset();
    rst = 1; init = 1; resync = 1; mac = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (act1 !== 11'h0 || act0 !== 11'h0) begin
        n_fail++;
        $display("FAIL reset: got %h / %h, want 000", act1, act0);
      end
    end
    resync = 0; mac = 0;
  endtask

  task automatic test_startup();
    int n = 0;
    rst = 0; init = 1;
    tick();
    while (!enc1 && n < 20) begin
      tick();
      n++;
      n_cmp++;
      if (act1 !== exp_vec(1) || act0 !== exp_vec(0)) begin
        n_fail++;
        $display("FAIL startup: got %h/%h want %h/%h", act1, act0, exp_vec(1), exp_vec(0));
      end
    end
    n_cmp++;
    if (n != INIT_HOLD) begin
      n_fail++;
      $display("FAIL startup_hold_len: got %0d cycles, want %0d", n, INIT_HOLD);
    end
    n_cmp++;
    if ({seq1, fw1, rdy1, pause1} !== {6'd0, 1'b0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL first_run: seq=%0d fw=%b rdy=%b pause=%b, want 0 0 1 0", seq1, fw1, rdy1, pause1);
    end
  endtask

  task automatic test_periods();
    int np = 0, nr1 = 0, nr0 = 0;
    for (int i = 0; i < 3 * (SEQ_MAX + 1); i++) begin
      tick();
      if (pause1) np++;
      if (!rdy1) nr1++;
      if (!rdy0) nr0++;
      n_cmp++;
      if (act1 !== exp_vec(1) || act0 !== exp_vec(0)) begin
        n_fail++;
        $display("FAIL periods: got %h/%h want %h/%h", act1, act0, exp_vec(1), exp_vec(0));
      end
    end
    n_cmp++;
    if (np != 3 || nr1 != 3 || nr0 != 3) begin
      n_fail++;
      $display("FAIL period_counts: pause=%0d rdy1_low=%0d rdy0_low=%0d, want 3 3 3", np, nr1, nr0);
    end
  endtask

  task automatic test_resync();
    run_until(SEQ_MAX - 1, "resync_31");
    resync = 1;
    tick();
    resync = 0;
    n_cmp++;
    if ({seq1, pause1, fw1, rdy1} !== {6'd0, 1'b0, 1'b0, 1'b1} || act1 !== exp_vec(1)) begin
      n_fail++;
      $display("FAIL resync_at_31: got %h want seq0/pause0/fw0/rdy1 (%h)", act1, exp_vec(1));
    end
    for (int i = 0; i < SEQ_MAX; i++) begin
      tick();
      n_cmp++;
      if (act1 !== exp_vec(1) || act0 !== exp_vec(0)) begin
        n_fail++;
        $display("FAIL resync_walk: got %h/%h want %h/%h", act1, act0, exp_vec(1), exp_vec(0));
      end
    end
    resync = 1;
    tick();
    resync = 0;
    n_cmp++;
    if ({seq1, pause1, fw1} !== 8'd0 || {seq0, pause0, fw0} !== 8'd0 || act1 !== exp_vec(1)) begin
      n_fail++;
      $display("FAIL resync_at_32: got %h/%h want %h", act1, act0, exp_vec(1));
    end
  endtask

  task automatic test_init_loss();
    int n = 0;
    run_until(17, "init_loss_17");
    init = 0;
    tick();
    n_cmp++;
    if ({seq1, pause1, fw1, rdy1, enc1} !== 10'd0 || act0[10:1] !== 10'd0) begin
      n_fail++;
      $display("FAIL init_loss: got %h/%h want outputs zero", act1, act0);
    end
    init = 1;
    tick();
    while (!enc1 && n < 20) begin
      tick();
      n++;
    end
    n_cmp++;
    if (n != INIT_HOLD || seq1 !== 6'd0 || act1 !== exp_vec(1)) begin
      n_fail++;
      $display("FAIL init_restore: hold=%0d seq=%0d, want %0d and 0", n, seq1, INIT_HOLD);
    end
  endtask

  task automatic test_seq_err();
    run_until(SEQ_MAX - 1, "seq_err_31");
    mac = 1;
    tick();
    mac = 0;
    n_cmp++;
    if (err1 !== 1'b1 || err0 !== 1'b0 || act1 !== exp_vec(1) || act0 !== exp_vec(0)) begin
      n_fail++;
      $display("FAIL seq_err_set: err1=%b err0=%b, want 1 0", err1, err0);
    end
    resync = 1;
    tick();
    resync = 0;
    init = 0;
    tick();
    tick();
    n_cmp++;
    if (err1 !== 1'b1 || enc1 !== 1'b0) begin
      n_fail++;
      $display("FAIL seq_err_sticky: err1=%b enc=%b, want 1 0", err1, enc1);
    end
    init = 1;
    rst = 1;
    tick();
    rst = 0;
    n_cmp++;
    if (err1 !== 1'b0 || act1 !== 11'h0) begin
      n_fail++;
      $display("FAIL seq_err_clear: got %h want 000", act1);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      rst    = ($urandom_range(0, 299) == 0);
      init   = ($urandom_range(0, 59) != 0);
      resync = ($urandom_range(0, 24) == 0);
      mac    = ($urandom_range(0, 9) == 0);
      tick();
      n_cmp++;
      if (act1 !== exp_vec(1) || act0 !== exp_vec(0)) begin
        n_fail++;
        $display("FAIL random cyc %0d: got %h/%h want %h/%h", i, act1, act0, exp_vec(1), exp_vec(0));
      end
    end
    rst = 0; resync = 0; mac = 0; init = 1;
  endtask

  initial begin
    #2;
    test_reset();
    test_startup();
    test_periods();
    test_resync();
    test_init_loss();
    test_seq_err();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/tx_gearbox_sequencer.md
TX_GEARBOX_SEQUENCER -- requirements
Module: tx_gearbox_sequencer

Interface
REQ-001 SHALL have parameter SEQ_MAX, default 32, meaning last gearbox sequence value; a period is SEQ_MAX+1 cycles.
REQ-002 SHALL have parameter INIT_HOLD, default 4, meaning cycles spent in HOLD after init before RUN; legal range 1..255.
REQ-003 SHALL have parameter READY_LEAD, default 1, meaning cycles by which o_tx_ready leads o_tx_pause; legal values 0 or 1.
REQ-004 SHALL have one clock and a synchronous active-high reset: i_txc input 1 (sole clock, all logic on its rising edge); i_reset input 1.
REQ-005 i_init_done  input  1  transceiver init complete; level.
REQ-006 i_force_resync  input  1  single-cycle pulse; restart sequence at 0.
REQ-007 i_mac_valid  input  1  MAC presenting a word this cycle.
REQ-008 o_gearbox_seq  output  6  gearbox sequence counter to transceiver.
REQ-009 o_tx_pause  output  1  gearbox pause to encoder.
REQ-010 o_frame_word  output  1  0 = first 32-bit half of a 64b block, 1 = second half; to encoder.
REQ-011 o_tx_ready  output  1  MAC may present a new word.
REQ-012 o_enc_init_done  output  1  gated init to encoder; high only in RUN.
REQ-013 o_seq_err  output  1  sticky; MAC presented a word while not ready.

Function
REQ-014 SHALL implement states WAIT_INIT, HOLD, RUN; all outputs registered.
REQ-015 WAIT_INIT -> HOLD when i_init_done=1; HOLD -> RUN after INIT_HOLD consecutive cycles with i_init_done=1.
REQ-016 In RUN or HOLD, i_init_done=0 -> WAIT_INIT next cycle; sequence state is cleared.
REQ-017 Outside RUN: o_gearbox_seq=0, o_tx_pause=0, o_frame_word=0, o_tx_ready=0, o_enc_init_done=0.
REQ-018 In RUN, o_gearbox_seq is 0 on the first RUN cycle, increments by 1 per cycle, and wraps SEQ_MAX -> 0.
REQ-019 In RUN, o_tx_pause=1 exactly when o_gearbox_seq==SEQ_MAX: one cycle per period, 1 in 33 by default.
REQ-020 In RUN, o_frame_word = o_gearbox_seq[0] when seq<SEQ_MAX; when seq==SEQ_MAX it holds the previous value (1 by default).
REQ-021 READY_LEAD=0: o_tx_ready = RUN and not o_tx_pause, same cycle.
REQ-022 READY_LEAD=1: o_tx_ready low in the cycle where seq==SEQ_MAX-1 and high in the pause cycle; it is otherwise high in RUN, i.e. o_tx_ready is o_tx_pause advanced by one cycle and inverted.
REQ-023 The first RUN cycle SHALL have o_tx_ready=1, given seq 0 and no pause next.
REQ-024 i_force_resync=1 in RUN: the next cycle has seq=0, frame_word=0, pause=0, and the ready pattern restarts as from the first RUN cycle; this takes priority over the wrap and over a pending pause.
REQ-025 i_force_resync outside RUN SHALL be ignored.
REQ-026 If i_force_resync and i_init_done=0 occur together, the block SHALL go to WAIT_INIT.
REQ-027 o_seq_err SHALL set the cycle after i_mac_valid=1 with o_tx_ready=0 while in RUN; it holds until i_reset.
REQ-028 i_mac_valid outside RUN SHALL be ignored.
REQ-029 The counter SHALL be the minimum width for SEQ_MAX and zero-extended onto o_gearbox_seq.

Reset
REQ-030 i_reset=1 SHALL force the following in the next cycle, overriding all inputs: state WAIT_INIT, HOLD counter 0, all outputs 0, o_seq_err cleared.
REQ-031 Reset mid-period SHALL discard sequence position; after release the sequence restarts only via WAIT_INIT -> HOLD -> RUN.

Verification
REQ-032 Reset, then hold i_init_done=1 -> o_enc_init_done rises exactly 4 cycles after entering HOLD; the first RUN cycle has seq=0, fw=0, ready=1.
REQ-033 Run 3 periods, defaults -> pause at seq=32 only (every 33 cycles); fw toggles 0,1..., is 1 at seq 31 and 32, and 0 at seq 0; ready=0 only at seq=31.
REQ-034 READY_LEAD=0 -> ready=0 only at seq=32, coincident with pause.
REQ-035 Pulse i_force_resync at seq=31 and again at seq=32 -> next cycle seq=0, pause=0, fw=0; no pause is emitted for the interrupted period.
REQ-036 Drop i_init_done at seq=17 -> next cycle all outputs 0 in WAIT_INIT; restore -> full HOLD of 4 cycles before seq=0.
REQ-037 Assert i_mac_valid at seq=31 -> o_seq_err=1 the next cycle and stays 1 through resync and init loss; clears only on i_reset.
